// File: rtl/clk_period_meter_if.sv
// clk_period_meter_if: measured signal in, period/high-time/status results out.
interface clk_period_meter_if #(parameter int CW = 26);
  logic          sig_in;
  logic [CW-1:0] period_out;
  logic [CW-1:0] high_out;
  logic          valid;
  logic          locked;
  logic          timeout;
  modport master (output sig_in, input period_out, high_out, valid, locked, timeout);
  modport slave  (input sig_in, output period_out, high_out, valid, locked, timeout);
endinterface

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures sig_in period in clk cycles with lock/timeout status.
// Define CLK_PERIOD_METER_HIGH_TIME_EN to also measure high time; otherwise high_out is 0.
module clk_period_meter #(
  parameter int MAX_COUNT   = 50_000_000,
  parameter int SYNC_STAGES = 2,
  localparam int CW         = $clog2(MAX_COUNT + 1)
) (
  input logic              clk,
  input logic              rst,
  clk_period_meter_if.slave bus
);
  typedef enum logic {IDLE, MEASURE} state_t;
  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          period_q;
  logic                   valid_q;
  logic                   locked_q;
  logic                   timeout_q;
  logic                   s_sync;
  logic                   rise;
  assign s_sync = sync_q[SYNC_STAGES-1];
  assign rise   = s_sync & ~s_d_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
      s_d_q  <= s_sync;
    end
  end
`ifdef CLK_PERIOD_METER_HIGH_TIME_EN
  logic [CW-1:0] hcnt_q;
  logic [CW-1:0] high_q;
  assign bus.high_out = high_q;
`else
  assign bus.high_out = '0;
`endif
  // Timeout is tested before incrementing, so cnt_q never passes MAX_COUNT-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
`ifdef CLK_PERIOD_METER_HIGH_TIME_EN
      hcnt_q    <= '0;
      high_q    <= '0;
`endif
    end else begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      if (state_q == IDLE) begin
        cnt_q <= '0;
`ifdef CLK_PERIOD_METER_HIGH_TIME_EN
        hcnt_q <= '0;
`endif
        if (rise) state_q <= MEASURE;
      end else if (rise) begin
        period_q <= cnt_q + CW'(1);
        valid_q  <= 1'b1;
        locked_q <= 1'b1;
        cnt_q    <= '0;
`ifdef CLK_PERIOD_METER_HIGH_TIME_EN
        high_q   <= hcnt_q + CW'(1);
        hcnt_q   <= '0;
`endif
      end else if (cnt_q == CW'(MAX_COUNT - 1)) begin
        timeout_q <= 1'b1;
        locked_q  <= 1'b0;
        cnt_q     <= '0;
        state_q   <= IDLE;
      end else begin
        cnt_q <= cnt_q + CW'(1);
`ifdef CLK_PERIOD_METER_HIGH_TIME_EN
        hcnt_q <= hcnt_q + CW'(s_sync);
`endif
      end
    end
  end
  assign bus.period_out = period_q;
  assign bus.valid      = valid_q;
  assign bus.locked     = locked_q;
  assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: random and directed stimulus against an edge-timing reference model.
module tb_clk_period_meter;
  localparam int MAXC = 100;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int LAT  = 3;
  typedef struct {int due; bit tout; int period; int high;} ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  clk_period_meter_if #(.CW(CW)) bus ();
  clk_period_meter #(.MAX_COUNT(MAXC), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  ev_t q[$];
  int cyc = 0, checks = 0, passes = 0;
  int n_valid = 0, n_tout = 0, last_valid_cyc = 0, last_tout_cyc = 0;
  bit armed = 0, prev = 0;
  int last = 0, hm = 0;
  logic          exp_locked = 1'b0;
  logic [CW-1:0] exp_period = '0, exp_high = '0;
  logic [2*CW+2:0] obs, exp_v;
  // One clk cycle: sample outputs and build the expectation, then drive and advance the model.
  task automatic step(input logic v, input logic r);
    ev_t e;
    logic ev, et;
    @(negedge clk);
    obs = {bus.valid, bus.timeout, bus.locked, bus.period_out, bus.high_out};
    if (bus.valid === 1'b1) begin n_valid++; last_valid_cyc = cyc; end
    if (bus.timeout === 1'b1) begin n_tout++; last_tout_cyc = cyc; end
    ev = 1'b0;
    et = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      if (e.tout) begin
        et = 1'b1;
        exp_locked = 1'b0;
      end else begin
        ev = 1'b1;
        exp_locked = 1'b1;
        exp_period = CW'(e.period);
`ifdef CLK_PERIOD_METER_HIGH_TIME_EN
        exp_high = CW'(e.high);
`else
        exp_high = '0;
`endif
      end
    end
    exp_v = {ev, et, exp_locked, exp_period, exp_high};
    bus.sig_in = v;
    rst = r;
    if (r) begin
      q.delete();
      armed = 0; prev = 0;
      exp_locked = 1'b0; exp_period = '0; exp_high = '0;
    end else begin
      if (armed) begin
        if (v && !prev) begin
          q.push_back('{due: cyc + LAT, tout: 1'b0, period: cyc - last, high: hm});
          last = cyc; hm = 1;
        end else if (cyc - last == MAXC) begin
          q.push_back('{due: cyc + LAT, tout: 1'b1, period: 0, high: 0});
          armed = 0;
        end else if (v) hm++;
      end else if (v && !prev) begin
        armed = 1; last = cyc; hm = 1;
      end
      prev = v;
    end
    cyc++;
  endtask
  task automatic rst_pulse();
    step(1'b0, 1'b1);
  endtask
  task automatic test_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    checks++;
    if (obs !== '0) $display("FAIL reset_state got=%h exp=0", obs);
    else passes++;
  endtask
  task automatic test_period10();
    int v0 = n_valid;
    rst_pulse();
    for (int i = 0; i < 60; i++) begin
      step(logic'((i % 10) < 5), 1'b0);
      checks++;
      if (obs !== exp_v) $display("FAIL period10 cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      else passes++;
    end
    checks++;
    if (bus.period_out !== CW'(10) || bus.locked !== 1'b1 || n_valid - v0 != 5)
      $display("FAIL period10_final period=%0d locked=%b valids=%0d exp 10/1/5", bus.period_out, bus.locked, n_valid - v0);
    else passes++;
  endtask
  task automatic test_high_time();
    logic [CW-1:0] hexp;
`ifdef CLK_PERIOD_METER_HIGH_TIME_EN
    hexp = CW'(3);
`else
    hexp = '0;
`endif
    rst_pulse();
    for (int i = 0; i < 60; i++) begin
      step(logic'((i % 10) < 3), 1'b0);
      checks++;
      if (obs !== exp_v) $display("FAIL high_time cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      else passes++;
    end
    checks++;
    if (bus.period_out !== CW'(10) || bus.high_out !== hexp)
      $display("FAIL high_time_final period=%0d high=%0d exp 10/%0d", bus.period_out, bus.high_out, hexp);
    else passes++;
  endtask
  task automatic test_timeout();
    int v0, t0;
    rst_pulse();
    for (int i = 0; i < 30; i++) begin
      step(logic'((i % 10) < 5), 1'b0);
      checks++;
      if (obs !== exp_v) $display("FAIL timeout_lock cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      else passes++;
    end
    v0 = n_valid;
    t0 = n_tout;
    for (int i = 0; i < 130; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (obs !== exp_v) $display("FAIL timeout_hold cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      else passes++;
    end
    checks++;
    if (n_tout - t0 != 1 || n_valid != v0 || bus.locked !== 1'b0 || bus.period_out !== CW'(10)
        || last_tout_cyc - last_valid_cyc != MAXC)
      $display("FAIL timeout_final touts=%0d valids=%0d locked=%b period=%0d gap=%0d exp 1/0/0/10/%0d",
               n_tout - t0, n_valid - v0, bus.locked, bus.period_out, last_tout_cyc - last_valid_cyc, MAXC);
    else passes++;
  endtask
  task automatic test_boundary();
    int gaps[5] = '{100, 100, 101, 50, 10};
    int v0, t0;
    rst_pulse();
    v0 = n_valid;
    t0 = n_tout;
    foreach (gaps[g]) begin
      for (int j = 0; j < gaps[g]; j++) begin
        step(logic'(j == 0), 1'b0);
        checks++;
        if (obs !== exp_v) $display("FAIL boundary cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
        else passes++;
      end
      if (g == 1) begin
        checks++;
        if (bus.period_out !== CW'(MAXC) || n_tout != t0)
          $display("FAIL boundary_max period=%0d touts=%0d exp %0d/0", bus.period_out, n_tout - t0, MAXC);
        else passes++;
      end
    end
    checks++;
    if (n_valid - v0 != 3 || n_tout - t0 != 1 || bus.period_out !== CW'(50) || bus.locked !== 1'b1)
      $display("FAIL boundary_final valids=%0d touts=%0d period=%0d locked=%b exp 3/1/50/1",
               n_valid - v0, n_tout - t0, bus.period_out, bus.locked);
    else passes++;
  endtask
  task automatic test_reset_mid();
    int v0;
    rst_pulse();
    for (int i = 0; i < 27; i++) begin
      step(logic'((i % 10) < 5), 1'b0);
      checks++;
      if (obs !== exp_v) $display("FAIL reset_mid_lock cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      else passes++;
    end
    checks++;
    if (bus.locked !== 1'b1) $display("FAIL reset_mid_locked got=%b exp=1", bus.locked);
    else passes++;
    step(1'b0, 1'b1);
    v0 = n_valid;
    for (int i = 28; i < 50; i++) begin
      step(logic'((i % 10) < 5), 1'b0);
      checks++;
      if (obs !== exp_v) $display("FAIL reset_mid cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      else passes++;
      if (i == 28) begin
        checks++;
        if (obs !== '0) $display("FAIL reset_mid_zero got=%h exp=0", obs);
        else passes++;
      end
    end
    checks++;
    if (n_valid - v0 != 1 || bus.period_out !== CW'(10))
      $display("FAIL reset_mid_final valids=%0d period=%0d exp 1/10", n_valid - v0, bus.period_out);
    else passes++;
  endtask
  task automatic test_period2();
    int v0, t0;
    rst_pulse();
    v0 = n_valid;
    t0 = n_tout;
    for (int i = 0; i < 40; i++) begin
      step(logic'(i % 2 == 0), 1'b0);
      checks++;
      if (obs !== exp_v) $display("FAIL period2 cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      else passes++;
    end
    checks++;
    if (bus.period_out !== CW'(2) || n_tout != t0 || n_valid - v0 != 18)
      $display("FAIL period2_final period=%0d touts=%0d valids=%0d exp 2/0/18", bus.period_out, n_tout - t0, n_valid - v0);
    else passes++;
  endtask
  task automatic test_random();
    int hi, lo;
    rst_pulse();
    for (int s = 0; s < 40; s++) begin
      hi = $urandom_range(1, 20);
      lo = ($urandom_range(0, 7) == 0) ? $urandom_range(85, 130) : $urandom_range(1, 40);
      for (int j = 0; j < hi + lo; j++) begin
        step(logic'(j < hi), 1'b0);
        checks++;
        if (obs !== exp_v) $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
        else passes++;
      end
    end
    for (int j = 0; j < 5; j++) begin
      step(1'b0, 1'b0);
      checks++;
      if (obs !== exp_v) $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      else passes++;
    end
  endtask
  initial begin
    bus.sig_in = 1'b0;
    test_reset();
    test_period10();
    test_high_time();
    test_timeout();
    test_boundary();
    test_reset_mid();
    test_period2();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
